// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks in-flight register writes across the
// post-decode stages and derives bypass selects plus stall/bubble requests.
module hazard_scoreboard #(
    parameter int REG_W      = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 2,
    parameter int MD_LAT     = 32,
    parameter int FW         = $clog2(STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_stall,
    input  logic [REG_W-1:0]             rs_D,
    input  logic [REG_W-1:0]             rt_D,
    input  logic                         rs_use_D,
    input  logic                         rt_use_D,
    input  logic                         wr_en_D,
    input  logic [REG_W-1:0]             wr_reg_D,
    input  logic                         is_load_D,
    input  logic                         md_start_D,
    input  logic                         hilo_access_D,
    input  logic                         flush_D,
    output logic [FW-1:0]                fwd_a_D,
    output logic [FW-1:0]                fwd_b_D,
    output logic                         stall_D,
    output logic                         bubble_E,
    output logic                         md_busy,
    output logic [$clog2(MD_LAT+1)-1:0]  md_count
);

    localparam int MCW = $clog2(MD_LAT + 1);

    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] load_reg;
    logic [REG_W-1:0]  dst_reg [STAGES];
    logic [MCW-1:0]    mdc_reg;

    logic [STAGES-1:0] match_a;
    logic [STAGES-1:0] match_b;
    logic              load_hit_a;
    logic              load_hit_b;
    logic              md_hazard;
    logic              raw_stall;
    logic              valid_next;
    logic              md_go;

    // Register 0 is hardwired zero, so it never matches a producer.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_match
        assign match_a[gi] = rs_use_D && (rs_D != '0) && valid_reg[gi] && (dst_reg[gi] == rs_D);
        assign match_b[gi] = rt_use_D && (rt_D != '0) && valid_reg[gi] && (dst_reg[gi] == rt_D);
    end

    // Scan oldest to youngest so the youngest matching producer is left standing.
    always_comb begin
        fwd_a_D    = '0;
        fwd_b_D    = '0;
        load_hit_a = 1'b0;
        load_hit_b = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (match_a[k]) begin
                fwd_a_D    = FW'(k + 1);
                load_hit_a = load_reg[k] && (k < LOAD_READY);
            end
            if (match_b[k]) begin
                fwd_b_D    = FW'(k + 1);
                load_hit_b = load_reg[k] && (k < LOAD_READY);
            end
        end
    end

    assign md_hazard  = (mdc_reg != '0) && (hilo_access_D || md_start_D);
    assign raw_stall  = load_hit_a || load_hit_b || md_hazard;
    assign stall_D    = mem_stall || raw_stall;
    assign bubble_E   = raw_stall && !mem_stall;
    assign md_busy    = (mdc_reg != '0);
    assign md_count   = mdc_reg;

    assign valid_next = wr_en_D && !raw_stall && !flush_D && (wr_reg_D != '0);
    assign md_go      = !mem_stall && md_start_D && !raw_stall && !flush_D;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg[0] <= 1'b0;
            load_reg[0]  <= 1'b0;
            dst_reg[0]   <= '0;
        end else if (!mem_stall) begin
            valid_reg[0] <= valid_next;
            load_reg[0]  <= is_load_D;
            dst_reg[0]   <= wr_reg_D;
        end
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_reg[gi] <= 1'b0;
                load_reg[gi]  <= 1'b0;
                dst_reg[gi]   <= '0;
            end else if (!mem_stall) begin
                valid_reg[gi] <= valid_reg[gi-1];
                load_reg[gi]  <= load_reg[gi-1];
                dst_reg[gi]   <= dst_reg[gi-1];
            end
        end
    end

    // The multiply/divide unit keeps counting through memory stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdc_reg <= '0;
        end else if (md_go) begin
            mdc_reg <= MCW'(MD_LAT);
        end else if (mdc_reg != '0) begin
            mdc_reg <= mdc_reg - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with STAGES=3, LOAD_READY=2, MD_LAT=4.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_stall;
    logic [4:0] rs_D, rt_D, wr_reg_D;
    logic       rs_use_D, rt_use_D, wr_en_D, is_load_D;
    logic       md_start_D, hilo_access_D, flush_D;
    logic [1:0] fwd_a_D, fwd_b_D;
    logic       stall_D, bubble_E, md_busy;
    logic [2:0] md_count;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard #(
        .REG_W(5), .STAGES(3), .LOAD_READY(2), .MD_LAT(4)
    ) dut (
        .clk(clk), .reset(reset), .mem_stall(mem_stall),
        .rs_D(rs_D), .rt_D(rt_D), .rs_use_D(rs_use_D), .rt_use_D(rt_use_D),
        .wr_en_D(wr_en_D), .wr_reg_D(wr_reg_D), .is_load_D(is_load_D),
        .md_start_D(md_start_D), .hilo_access_D(hilo_access_D), .flush_D(flush_D),
        .fwd_a_D(fwd_a_D), .fwd_b_D(fwd_b_D), .stall_D(stall_D), .bubble_E(bubble_E),
        .md_busy(md_busy), .md_count(md_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic clear_in();
        mem_stall = 0; rs_D = 0; rt_D = 0; rs_use_D = 0; rt_use_D = 0;
        wr_en_D = 0; wr_reg_D = 0; is_load_D = 0;
        md_start_D = 0; hilo_access_D = 0; flush_D = 0;
    endtask

    task automatic write_reg(input int r, input bit ld);
        clear_in();
        wr_en_D = 1; wr_reg_D = 5'(r); is_load_D = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        clear_in();
        #2;
        check_eq("rst_fwd_a", fwd_a_D, 0);
        check_eq("rst_stall", stall_D, 0);
        check_eq("rst_bubble", bubble_E, 0);
        check_eq("rst_md_busy", md_busy, 0);
        #5 reset = 0;
        tick();

        // Producer-distance sweep
        write_reg(5, 0);
        tick();
        clear_in(); rs_D = 5; rs_use_D = 1;
        #1;
        check_eq("dist1_fwd_a", fwd_a_D, 1);
        check_eq("dist1_stall", stall_D, 0);
        tick(); #1;
        check_eq("dist2_fwd_a", fwd_a_D, 2);
        tick(); #1;
        check_eq("dist3_fwd_a", fwd_a_D, 3);
        check_eq("dist3_stall", stall_D, 0);
        tick(); #1;
        check_eq("dist4_fwd_a", fwd_a_D, 0);

        // Load-use: load at stage 0 and 1 both interlock, forwarded from W
        write_reg(8, 1);
        tick();
        clear_in(); rt_D = 8; rt_use_D = 1;
        #1;
        check_eq("lu_k0_stall", stall_D, 1);
        check_eq("lu_k0_bubble", bubble_E, 1);
        check_eq("lu_k0_fwd_b", fwd_b_D, 1);
        tick(); #1;
        check_eq("lu_k1_stall", stall_D, 1);
        check_eq("lu_k1_bubble", bubble_E, 1);
        tick(); #1;
        check_eq("lu_k2_stall", stall_D, 0);
        check_eq("lu_k2_bubble", bubble_E, 0);
        check_eq("lu_k2_fwd_b", fwd_b_D, 3);

        // Youngest producer wins; same register on both operands
        write_reg(3, 0); tick();
        write_reg(4, 0); tick();
        write_reg(3, 0); tick();
        clear_in(); rs_D = 3; rs_use_D = 1; rt_D = 3; rt_use_D = 1;
        #1;
        check_eq("young_fwd_a", fwd_a_D, 1);
        check_eq("young_fwd_b", fwd_b_D, 1);
        write_reg(0, 0); tick();
        clear_in(); rs_D = 0; rs_use_D = 1; rt_D = 4; rt_use_D = 1;
        #1;
        check_eq("r0_fwd_a", fwd_a_D, 0);
        check_eq("r4_fwd_b", fwd_b_D, 3);

        // mem_stall freeze with r7 at stage 0
        write_reg(7, 0); tick();
        clear_in(); mem_stall = 1; rs_D = 7; rs_use_D = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("ms%0d_fwd_a", i), fwd_a_D, 1);
            check_eq($sformatf("ms%0d_stall", i), stall_D, 1);
            check_eq($sformatf("ms%0d_bubble", i), bubble_E, 0);
            tick();
        end
        mem_stall = 0;
        #1;
        check_eq("msrel_fwd_a", fwd_a_D, 1);
        check_eq("msrel_stall", stall_D, 0);
        tick(); #1;
        check_eq("msadv_fwd_a", fwd_a_D, 2);

        // Multiply/divide interlock
        clear_in(); md_start_D = 1;
        #1;
        check_eq("md_start_stall", stall_D, 0);
        check_eq("md_start_count", md_count, 0);
        tick();
        clear_in(); hilo_access_D = 1;
        for (int c = 4; c >= 0; c--) begin
            #1;
            check_eq($sformatf("md_count_%0d", c), md_count, c);
            check_eq($sformatf("md_stall_%0d", c), stall_D, (c != 0) ? 1 : 0);
            check_eq($sformatf("md_busy_%0d", c), md_busy, (c != 0) ? 1 : 0);
            tick();
        end

        // Flush: md_start not recorded; load-use still bubbles, write dropped
        clear_in(); md_start_D = 1; flush_D = 1;
        tick(); #1;
        check_eq("flush_md_count", md_count, 0);
        write_reg(10, 1); tick();
        clear_in(); rt_D = 10; rt_use_D = 1; wr_en_D = 1; wr_reg_D = 11; flush_D = 1;
        #1;
        check_eq("flush_lu_bubble", bubble_E, 1);
        check_eq("flush_lu_stall", stall_D, 1);
        tick();
        clear_in(); rs_D = 11; rs_use_D = 1;
        #1;
        check_eq("flush_nowrite_fwd_a", fwd_a_D, 0);

        // Async reset mid multiply/divide
        write_reg(5, 0); md_start_D = 1;
        tick();
        clear_in(); rs_D = 5; rs_use_D = 1; hilo_access_D = 1;
        #1;
        check_eq("pre_rst_fwd_a", fwd_a_D, 1);
        check_eq("pre_rst_stall", stall_D, 1);
        check_eq("pre_rst_md_busy", md_busy, 1);
        #1 reset = 1;
        #1;
        check_eq("arst_fwd_a", fwd_a_D, 0);
        check_eq("arst_md_busy", md_busy, 0);
        check_eq("arst_md_count", md_count, 0);
        check_eq("arst_stall", stall_D, 0);
        #2 reset = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
